// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic OWN_CORE   = 1'b0;
   localparam logic OWN_LOADER = 1'b1;

   localparam int CNT_W   = 3;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 7;

   // An out-of-range latency is clamped so the 3-bit counter never wraps.
   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      int v;
      v = lat;
      if (v < LAT_MIN) v = LAT_MIN;
      if (v > LAT_MAX) v = LAT_MAX;
      return CNT_W'(v - 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-input round-robin picker: on a tie the side not granted last wins.
module mem_arb_rr_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_gnt,
   output logic       o_valid
);

   always_comb begin
      o_valid = |i_req;
      o_gnt   = OWN_CORE;
      unique case (i_req)
         2'b01:   o_gnt = OWN_CORE;
         2'b10:   o_gnt = OWN_LOADER;
         2'b11:   o_gnt = ~i_last;
         default: o_gnt = OWN_CORE;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises core and loader accesses onto the single unified memory,
// one outstanding access, round-robin on ties, one-cycle ack.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_ack,
   output logic [DW-1:0] c_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_ack,
   output logic [DW-1:0] l_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = lat_load(LAT);

   state_t           r_state;
   state_t           w_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_own;
   logic             r_last;
   logic             r_we;
   logic [AW-1:0]    r_addr;
   logic [DW-1:0]    r_wdata;
   logic [DW-1:0]    r_c_rdata;
   logic [DW-1:0]    r_l_rdata;
   logic             w_gnt;
   logic             w_valid;
   logic             w_take;
   logic             w_last_cyc;

   mem_arb_rr_pick u_pick (
      .i_req   ({l_req, c_req}),
      .i_last  (r_last),
      .o_gnt   (w_gnt),
      .o_valid (w_valid)
   );

   assign w_take     = (r_state == IDLE) && w_valid;
   assign w_last_cyc = (r_state == ACCESS) && (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_valid) w_nxt = ACCESS;
         ACCESS:  if (r_cnt == '0) w_nxt = RESP;
         RESP:    w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_en  = (r_state == ACCESS);
      m_we  = (r_state == ACCESS) && r_we;
      c_ack = (r_state == RESP) && (r_own == OWN_CORE);
      l_ack = (r_state == RESP) && (r_own == OWN_LOADER);
      busy  = (r_state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_own     <= OWN_CORE;
         r_last    <= OWN_LOADER;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_c_rdata <= '0;
         r_l_rdata <= '0;
      end else begin
         if (w_take) begin
            r_own   <= w_gnt;
            r_we    <= w_gnt ? l_we    : c_we;
            r_addr  <= w_gnt ? l_addr  : c_addr;
            r_wdata <= w_gnt ? l_wdata : c_wdata;
            r_cnt   <= CNT_LOAD;
         end
         if (r_state == ACCESS && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
         if (w_last_cyc && !r_we) begin
            if (r_own == OWN_CORE) r_c_rdata <= m_rdata;
            else                   r_l_rdata <= m_rdata;
         end
         if (r_state == RESP)
            r_last <= r_own;
      end
   end

   assign m_addr  = r_addr;
   assign m_wdata = r_wdata;
   assign c_rdata = r_c_rdata;
   assign l_rdata = r_l_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model
// predicts every ack (owner, cycle, data); a monitor checks them.
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          c_req = 1'b0, c_we = 1'b0;
   logic [AW-1:0] c_addr = '0;
   logic [DW-1:0] c_wdata = '0;
   logic          c_ack;
   logic [DW-1:0] c_rdata;
   logic          l_req = 1'b0, l_we = 1'b0;
   logic [AW-1:0] l_addr = '0;
   logic [DW-1:0] l_wdata = '0;
   logic          l_ack;
   logic [DW-1:0] l_rdata;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
      .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr),
      .l_wdata(l_wdata), .l_ack(l_ack), .l_rdata(l_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
   );

   int errs = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name, input string what);
      checks++;
      errs++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Memory macro: combinational read, write on the clock edge.
   logic [31:0] seed [16];
   logic [31:0] mem  [16];
   assign m_rdata = mem[m_addr[5:2]];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= seed[i];
      end else if (m_en && m_we) begin
         mem[m_addr[5:2]] <= m_wdata;
      end
   end

   typedef struct {
      logic        own;
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];

   // Reference model: decision when free and a request is seen,
   // ack LAT+1 cycles later, free again one cycle after the ack.
   logic [31:0] ref_mem [16];
   logic [31:0] rc = '0, rl = '0;
   logic        last = 1'b1;
   int          free_at = 0;
   int          b_lo = 1, b_hi = 0, a_hi = 0;
   logic        e_we = 1'b0;
   logic [31:0] e_addr = '0, e_wdata = '0;
   logic        own;
   logic        in_acc;
   exp_t        e;

   always @(negedge clk) begin
      in_acc = (cyc >= b_lo) && (cyc <= a_hi);
      chk("busy", 64'(busy), 64'((cyc >= b_lo) && (cyc <= b_hi)));
      chk("m_en", 64'(m_en), 64'(in_acc));
      chk("m_we", 64'(m_we), 64'(in_acc && e_we));
      if (in_acc) begin
         chk("m_addr", 64'(m_addr), 64'(e_addr));
         if (e_we) chk("m_wdata", 64'(m_wdata), 64'(e_wdata));
      end
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) ref_mem[i] = seed[i];
         rc = '0;
         rl = '0;
         last = 1'b1;
         free_at = cyc + 1;
         if (b_hi > cyc) b_hi = cyc;
         if (a_hi > cyc) a_hi = cyc;
         while (q.size() > 0 && q[q.size()-1].cyc > cyc)
            void'(q.pop_back());
      end else if (cyc >= free_at && (c_req || l_req)) begin
         own     = (c_req && l_req) ? ~last : l_req;
         e_we    = own ? l_we    : c_we;
         e_addr  = own ? l_addr  : c_addr;
         e_wdata = own ? l_wdata : c_wdata;
         if (e_we)     ref_mem[e_addr[5:2]] = e_wdata;
         else if (own) rl = ref_mem[e_addr[5:2]];
         else          rc = ref_mem[e_addr[5:2]];
         e.own  = own;
         e.cyc  = cyc + LAT + 1;
         e.data = own ? rl : rc;
         q.push_back(e);
         last    = own;
         b_lo    = cyc + 1;
         a_hi    = cyc + LAT;
         b_hi    = cyc + LAT + 1;
         free_at = cyc + LAT + 2;
      end
   end

   exp_t m;

   always @(negedge clk) begin
      if (c_ack && l_ack)
         note_fail("dual_ack", "both acks high together");
      if (c_ack || l_ack) begin
         if (q.size() == 0) begin
            note_fail("spurious_ack", "ack with nothing expected");
         end else begin
            m = q.pop_front();
            chk("ack_owner", 64'(l_ack), 64'(m.own));
            chk("ack_cycle", 64'(cyc), 64'(m.cyc));
            chk("ack_rdata", 64'(l_ack ? l_rdata : c_rdata),
                64'(m.data));
         end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
         note_fail("missing_ack", "expected ack did not appear");
         void'(q.pop_front());
      end
   end

   task automatic c_txn(input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      int n;
      c_we = we; c_addr = a; c_wdata = d; c_req = 1'b1;
      n = 0;
      @(negedge clk);
      while (!c_ack && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!c_ack) note_fail("core_timeout", "no c_ack within bound");
      @(posedge clk); #1 c_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic l_txn(input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      int n;
      l_we = we; l_addr = a; l_wdata = d; l_req = 1'b1;
      n = 0;
      @(negedge clk);
      while (!l_ack && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!l_ack) note_fail("ldr_timeout", "no l_ack within bound");
      @(posedge clk); #1 l_req = 1'b0;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] raddr();
      return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
   endfunction

   initial begin
      int n;
      int k;
      for (int i = 0; i < 16; i++) seed[i] = $urandom;
      seed[4] = 32'hDEADBEEF;

      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_c_ack",   64'(c_ack),   64'd0);
      chk("rst_l_ack",   64'(l_ack),   64'd0);
      chk("rst_m_en",    64'(m_en),    64'd0);
      chk("rst_m_we",    64'(m_we),    64'd0);
      chk("rst_m_addr",  64'(m_addr),  64'd0);
      chk("rst_m_wdata", 64'(m_wdata), 64'd0);
      chk("rst_c_rdata", 64'(c_rdata), 64'd0);
      chk("rst_l_rdata", 64'(l_rdata), 64'd0);
      chk("rst_busy",    64'(busy),    64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Both requesting from reset release: core first, then alternate.
      fork
         begin
            c_txn(1'b0, 32'h04, 32'h0);
            c_txn(1'b0, 32'h0C, 32'h0);
         end
         begin
            l_txn(1'b0, 32'h08, 32'h0);
            l_txn(1'b0, 32'h18, 32'h0);
         end
      join

      c_txn(1'b0, 32'h10, 32'h0);
      chk("core_read_deadbeef", 64'(c_rdata), 64'h0DEADBEEF);

      l_txn(1'b1, 32'h00, 32'h00000013);
      c_txn(1'b0, 32'h00, 32'h0);
      chk("core_sees_ldr_write", 64'(c_rdata), 64'h13);

      // Core drops its request in the second ACCESS cycle.
      c_we = 1'b0; c_addr = 32'h08; c_req = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 c_req = 1'b0;
      n = 0;
      while (!c_ack && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!c_ack) note_fail("drop_timeout", "no c_ack after drop");
      @(posedge clk); #1;

      // Reset in the middle of an access aborts it.
      c_we = 1'b0; c_addr = 32'h14; c_req = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b0; c_req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_m_en", 64'(m_en), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      fork
         c_txn(1'b0, 32'h1C, 32'h0);
         l_txn(1'b0, 32'h2C, 32'h0);
      join

      // Loader write leaves l_rdata alone; the next read updates it.
      l_txn(1'b0, 32'h30, 32'h0);
      l_txn(1'b1, 32'h20, 32'hCAFE0001);
      l_txn(1'b0, 32'h24, 32'h0);
      l_txn(1'b0, 32'h20, 32'h0);
      chk("ldr_read_back", 64'(l_rdata), 64'hCAFE0001);

      fork
         begin
            for (int i = 0; i < 40; i++) begin
               k = $urandom_range(0, 3);
               repeat (k) begin @(posedge clk); #1; end
               c_txn(1'($urandom_range(0, 1)), raddr(), $urandom);
            end
         end
         begin
            for (int j = 0; j < 40; j++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk); #1;
               end
               l_txn(1'($urandom_range(0, 1)), raddr(), $urandom);
            end
         end
      join

      repeat (2 * LAT + 8) @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
